// File: rtl/lru_pkg.sv
// Shared types and helpers for the LRU access controller.
//   LRU_NUM_WAYS : default way count (must match the LRU tracker)
//   LRU_WAY_W    : way index width for the default way count
//   lru_state_e  : controller state encoding
//   onehot()     : way index to one-hot strobe (32-bit, caller truncates)
package lru_pkg;

  localparam int unsigned LRU_NUM_WAYS = 5;
  localparam int unsigned LRU_WAY_W    = $clog2(LRU_NUM_WAYS);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WAIT_VICTIM,
    FILL,
    TOUCH,
    CLEAR,
    RESP
  } lru_state_e;

  function automatic logic [31:0] onehot(input logic [31:0] way);
    return 32'(1) << way;
  endfunction

endpackage

// File: rtl/lru_tag_match.sv
// Combinational tag comparator and priority encoder over the tag table.
//   i_tags     : tag per way
//   i_valid    : valid bit per way
//   i_tag      : tag being looked up
//   o_hit      : some valid way holds i_tag
//   o_hit_way  : lowest matching way
//   o_free_any : some way is invalid
//   o_free_way : lowest invalid way
module lru_tag_match
  import lru_pkg::*;
#(
  parameter  int unsigned NUM_WAYS = LRU_NUM_WAYS,
  parameter  int unsigned TAG_W    = 8,
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0][TAG_W-1:0] i_tags,
  input  logic [NUM_WAYS-1:0]            i_valid,
  input  logic [TAG_W-1:0]               i_tag,
  output logic                           o_hit,
  output logic [WAY_W-1:0]               o_hit_way,
  output logic                           o_free_any,
  output logic [WAY_W-1:0]               o_free_way
);

  // Scan high to low so the lowest qualifying index is the one that sticks.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_way  = '0;
    o_free_any = 1'b0;
    o_free_way = '0;
    for (int i = int'(NUM_WAYS) - 1; i >= 0; i--) begin
      if (i_valid[i] && (i_tags[i] == i_tag)) begin
        o_hit     = 1'b1;
        o_hit_way = WAY_W'(i);
      end
      if (!i_valid[i]) begin
        o_free_any = 1'b1;
        o_free_way = WAY_W'(i);
      end
    end
  end

endmodule

// File: rtl/lru_access_ctrl.sv
// Initiator side of the LRU replacement interface: owns a fully-associative
// tag table, resolves lookups into hits, free-way fills or victim evictions,
// and strobes the LRU tracker (touch / clear) on its slow tick.
//   clk, rst         : clock, synchronous active-high reset
//   i_req_*/o_req_ready   : lookup request handshake and tag
//   o_resp_*/i_resp_ready : response handshake; hit, way, timeout error
//   o_touch          : one-hot access strobe to tracker, held until a tick
//   o_lru_clr        : clear request to tracker, held until a tick
//   i_lru_tick       : tracker sample strobe
//   i_victim_valid/i_victim_way : tracker's least-recently-used way
//   i_flush          : invalidate whole table (honoured only in IDLE)
module lru_access_ctrl
  import lru_pkg::*;
#(
  parameter  int unsigned NUM_WAYS = LRU_NUM_WAYS,
  parameter  int unsigned TAG_W    = 8,
  parameter  int unsigned TIMEOUT  = 255,
  localparam int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [TAG_W-1:0]    i_req_tag,
  output logic                o_resp_valid,
  input  logic                i_resp_ready,
  output logic                o_resp_hit,
  output logic [WAY_W-1:0]    o_resp_way,
  output logic                o_resp_err,
  output logic [NUM_WAYS-1:0] o_touch,
  output logic                o_lru_clr,
  input  logic                i_lru_tick,
  input  logic                i_victim_valid,
  input  logic [WAY_W-1:0]    i_victim_way,
  input  logic                i_flush
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  lru_state_e                    r_state, w_state_nxt;
  logic [NUM_WAYS-1:0][TAG_W-1:0] r_tags;
  logic [NUM_WAYS-1:0]           r_valid;
  logic [TAG_W-1:0]              r_tag_lat;
  logic [WAY_W-1:0]              r_way, w_way_nxt;
  logic                          r_hit, w_hit_nxt;
  logic                          r_err, w_err_nxt;
  logic [CNT_W-1:0]              r_cnt, w_cnt_nxt;
  logic [NUM_WAYS-1:0]           r_touch, w_touch_nxt;
  logic                          r_clr, w_clr_nxt;
  logic                          r_resp_valid, w_resp_valid_nxt;
  logic                          w_accept, w_fill, w_inval;

  logic                          w_hit, w_free_any;
  logic [WAY_W-1:0]              w_hit_way, w_free_way;

  lru_tag_match #(
    .NUM_WAYS (NUM_WAYS),
    .TAG_W    (TAG_W)
  ) u_match (
    .i_tags     (r_tags),
    .i_valid    (r_valid),
    .i_tag      (r_tag_lat),
    .o_hit      (w_hit),
    .o_hit_way  (w_hit_way),
    .o_free_any (w_free_any),
    .o_free_way (w_free_way)
  );

  assign o_req_ready  = (r_state == IDLE) && !i_flush && !rst;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_hit   = r_hit;
  assign o_resp_way   = r_way;
  assign o_resp_err   = r_err;
  assign o_touch      = r_touch;
  assign o_lru_clr    = r_clr;

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_way_nxt        = r_way;
    w_hit_nxt        = r_hit;
    w_err_nxt        = r_err;
    w_cnt_nxt        = r_cnt;
    w_touch_nxt      = r_touch;
    w_clr_nxt        = r_clr;
    w_resp_valid_nxt = r_resp_valid;
    w_accept         = 1'b0;
    w_fill           = 1'b0;
    w_inval          = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_flush) begin
          w_inval     = 1'b1;
          w_clr_nxt   = 1'b1;
          w_state_nxt = CLEAR;
        end else if (i_req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        w_err_nxt = 1'b0;
        w_hit_nxt = w_hit;
        if (w_hit) begin
          w_way_nxt   = w_hit_way;
          w_touch_nxt = NUM_WAYS'(onehot(32'(w_hit_way)));
          w_state_nxt = TOUCH;
        end else if (w_free_any) begin
          w_way_nxt   = w_free_way;
          w_state_nxt = FILL;
        end else begin
          w_cnt_nxt   = CNT_W'(TIMEOUT);
          w_state_nxt = WAIT_VICTIM;
        end
      end
      WAIT_VICTIM: begin
        // Out-of-range victim indices are treated as "no victim yet".
        if (i_victim_valid && (32'(i_victim_way) < NUM_WAYS)) begin
          w_way_nxt   = i_victim_way;
          w_state_nxt = FILL;
        end else if (r_cnt == '0) begin
          w_err_nxt        = 1'b1;
          w_hit_nxt        = 1'b0;
          w_way_nxt        = '0;
          w_resp_valid_nxt = 1'b1;
          w_state_nxt      = RESP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      FILL: begin
        w_fill      = 1'b1;
        w_touch_nxt = NUM_WAYS'(onehot(32'(r_way)));
        w_state_nxt = TOUCH;
      end
      TOUCH: begin
        if (i_lru_tick) begin
          w_touch_nxt      = '0;
          w_resp_valid_nxt = 1'b1;
          w_state_nxt      = RESP;
        end
      end
      CLEAR: begin
        if (i_lru_tick) begin
          w_clr_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      RESP: begin
        if (i_resp_ready) begin
          w_resp_valid_nxt = 1'b0;
          w_state_nxt      = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control state, response fields and valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_tag_lat    <= '0;
      r_way        <= '0;
      r_hit        <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_touch      <= '0;
      r_clr        <= 1'b0;
      r_resp_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_way        <= w_way_nxt;
      r_hit        <= w_hit_nxt;
      r_err        <= w_err_nxt;
      r_cnt        <= w_cnt_nxt;
      r_touch      <= w_touch_nxt;
      r_clr        <= w_clr_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      if (w_accept) r_tag_lat <= i_req_tag;
      if (w_inval) r_valid <= '0;
      else if (w_fill) r_valid[r_way] <= 1'b1;
    end
  end

  // Tag storage; contents are only meaningful where the valid bit is set.
  always_ff @(posedge clk) begin
    if (w_fill) r_tags[r_way] <= r_tag_lat;
  end

endmodule

// File: tb/tb_lru_access_ctrl.sv
module tb_lru_access_ctrl;

  localparam int NW = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_req_valid, o_req_ready;
  logic [7:0] i_req_tag;
  logic       o_resp_valid, i_resp_ready, o_resp_hit, o_resp_err;
  logic [2:0] o_resp_way;
  logic [4:0] o_touch;
  logic       o_lru_clr, i_lru_tick, i_victim_valid, i_flush;
  logic [2:0] i_victim_way;

  always #5 clk = ~clk;

  lru_access_ctrl #(.NUM_WAYS(5), .TAG_W(8), .TIMEOUT(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_tag      (i_req_tag),
    .o_resp_valid   (o_resp_valid),
    .i_resp_ready   (i_resp_ready),
    .o_resp_hit     (o_resp_hit),
    .o_resp_way     (o_resp_way),
    .o_resp_err     (o_resp_err),
    .o_touch        (o_touch),
    .o_lru_clr      (o_lru_clr),
    .i_lru_tick     (i_lru_tick),
    .i_victim_valid (i_victim_valid),
    .i_victim_way   (i_victim_way),
    .i_flush        (i_flush)
  );

  typedef struct {
    bit hit;
    int way;
    bit err;
  } exp_t;

  exp_t     sb[$];
  int       n_cmp = 0;
  int       n_fail = 0;
  int       tick_mode = 0;  // 0 never, 1 random, 2 always
  int       rdy_mode = 2;   // 0 never, 1 random, 2 always
  bit [7:0] mtag[NW];
  bit       mval[NW];

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NW; i++) mval[i] = 1'b0;
  endfunction

  initial begin
    i_lru_tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (tick_mode)
        0:       i_lru_tick = 1'b0;
        1:       i_lru_tick = ($urandom_range(2) == 0);
        default: i_lru_tick = 1'b1;
      endcase
    end
  end

  initial begin
    i_resp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       i_resp_ready = 1'b0;
        1:       i_resp_ready = $urandom_range(1) == 1;
        default: i_resp_ready = 1'b1;
      endcase
    end
  end

  // Monitor: response scoreboard, touch expectation, invariants, hold stability.
  initial begin
    exp_t e;
    bit prev_rv = 0, prev_rr = 0, prev_hit = 0, prev_err = 0;
    int prev_way = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rv = 0;
      end else begin
        chk("touch_onehot", int'($countones(o_touch) <= 1), 1);
        chk("touch_clr_excl", int'((o_touch != 0) && o_lru_clr), 0);
        if (o_touch != 0) begin
          if (sb.size() == 0) chk("touch_unexpected", o_touch, 0);
          else begin
            e = sb[0];
            chk("touch_way", o_touch, e.err ? 0 : (1 << e.way));
          end
        end
        if (prev_rv && !prev_rr && o_resp_valid) begin
          chk("hold_hit", o_resp_hit, prev_hit);
          chk("hold_way", o_resp_way, prev_way);
          chk("hold_err", o_resp_err, prev_err);
        end
        if (o_resp_valid && i_resp_ready) begin
          if (sb.size() == 0) chk("resp_unexpected", 1, 0);
          else begin
            e = sb.pop_front();
            chk("resp_hit", o_resp_hit, e.hit);
            chk("resp_way", o_resp_way, e.way);
            chk("resp_err", o_resp_err, e.err);
          end
        end
        prev_rv  = o_resp_valid;
        prev_rr  = i_resp_ready;
        prev_hit = o_resp_hit;
        prev_way = o_resp_way;
        prev_err = o_resp_err;
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!o_req_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, int'(n < 2000), 1);
  endtask

  // Issue one request; the model decides the outcome from the table contents.
  // vway is the victim offered on a full miss (>= NW means an invalid index).
  task automatic issue(input logic [7:0] tag, input int vway, input int vdelay,
                       input bit wait_done);
    exp_t e;
    int   h = -1, f = -1;
    bit   full, evict;
    for (int i = 0; i < NW; i++) begin
      if (mval[i] && mtag[i] == tag && h < 0) h = i;
      if (!mval[i] && f < 0) f = i;
    end
    full  = (h < 0) && (f < 0);
    evict = full && (vway < NW);
    e.hit = (h >= 0);
    e.err = full && !evict;
    e.way = (h >= 0) ? h : (f >= 0) ? f : evict ? vway : 0;
    if (!e.hit && !e.err) begin
      mtag[e.way] = tag;
      mval[e.way] = 1'b1;
    end
    wait_idle("req_ready_timeout");
    sb.push_back(e);
    i_req_valid = 1'b1;
    i_req_tag   = tag;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    if (full) begin
      repeat (vdelay) begin
        @(posedge clk); #1;
      end
      i_victim_valid = 1'b1;
      i_victim_way   = 3'(vway);
    end
    if (wait_done) begin
      wait_idle("done_timeout");
      i_victim_valid = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] t;
    rst = 1'b1;
    i_req_valid = 0; i_req_tag = 0; i_victim_valid = 0; i_victim_way = 0; i_flush = 0;
    model_clear();
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rst_req_ready", o_req_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", o_resp_valid, 0);
    chk("rst_resp_hit", o_resp_hit, 0);
    chk("rst_resp_err", o_resp_err, 0);
    chk("rst_resp_way", o_resp_way, 0);
    chk("rst_touch", o_touch, 0);
    chk("rst_lru_clr", o_lru_clr, 0);
    chk("rst_req_ready_rel", o_req_ready, 1);
    tick_mode = 1; rdy_mode = 1;

    // Miss to free way, then fill the remaining ways.
    issue(8'h11, 0, 0, 1);
    for (int k = 8'h12; k <= 8'h15; k++) issue(8'(k), 0, 0, 1);

    // Minimum-latency hit with tick and ready permanently high.
    tick_mode = 2; rdy_mode = 2;
    repeat (2) begin
      @(posedge clk); #1;
    end
    issue(8'h13, 0, 0, 0);
    @(negedge clk); chk("lat_c1_rv", o_resp_valid, 0);
    @(negedge clk); chk("lat_c2_rv", o_resp_valid, 0);
    chk("lat_c2_touch", o_touch, 5'b00100);
    @(negedge clk); chk("lat_c3_rv", o_resp_valid, 1);
    wait_idle("lat_done");
    tick_mode = 1; rdy_mode = 1;

    // Eviction, re-miss of the evicted tag, hit on the new tag.
    issue(8'h20, 3, 10, 1);
    issue(8'h14, 1, 3, 1);
    issue(8'h20, 0, 0, 1);

    // Invalid victim held until timeout; table unchanged afterwards.
    issue(8'h30, 7, 0, 1);
    issue(8'h11, 0, 0, 1);

    // Tick withheld, then response backpressure.
    tick_mode = 0; rdy_mode = 2;
    repeat (2) begin
      @(posedge clk); #1;
    end
    issue(8'h13, 0, 0, 0);
    @(negedge clk);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk("bp_touch", o_touch, 5'b00100);
      chk("bp_no_resp", o_resp_valid, 0);
      chk("bp_req_ready", o_req_ready, 0);
    end
    rdy_mode = 0; tick_mode = 2;
    n = 0;
    while (!o_resp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_resp_seen", int'(n < 100), 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_resp_held", o_resp_valid, 1);
      chk("bp_req_ready_resp", o_req_ready, 0);
    end
    rdy_mode = 2;
    wait_idle("bp_done");
    tick_mode = 1; rdy_mode = 1;

    // Randomized traffic over a small tag set to mix hits, fills and evictions.
    for (int k = 0; k < 60; k++) begin
      t = 8'(8'h11 + $urandom_range(7));
      issue(t, ($urandom_range(7) == 0) ? 7 : int'($urandom_range(4)),
            int'($urandom_range(11)), 1);
    end

    // Flush wins over a simultaneous request; clear held until tick.
    tick_mode = 0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    i_flush = 1'b1; i_req_valid = 1'b1; i_req_tag = 8'h55;
    #1 chk("flush_req_ready", o_req_ready, 0);
    @(posedge clk); #1;
    i_flush = 1'b0; i_req_valid = 1'b0;
    model_clear();
    repeat (3) begin
      @(negedge clk);
      chk("flush_clr_held", o_lru_clr, 1);
      chk("flush_busy", o_req_ready, 0);
    end
    tick_mode = 2;
    wait_idle("flush_done");
    chk("flush_clr_drop", o_lru_clr, 0);
    tick_mode = 1;
    issue(8'h11, 0, 0, 1);

    // Reset while touch is being held.
    tick_mode = 0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    issue(8'h11, 0, 0, 0);
    n = 0;
    while (o_touch == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rt_touch_seen", int'(n < 100), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rt_req_ready_in_rst", o_req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rt_touch_drop", o_touch, 0);
    chk("rt_resp_valid", o_resp_valid, 0);
    sb.delete();
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("rt_req_ready_rel", o_req_ready, 1);
    tick_mode = 1;
    issue(8'h11, 0, 0, 1);

    repeat (5) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
